// File: rtl/clock_group_serial_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, DATA_W payload bits LSB first, stop bit.
// Every bit lasts DIV clk1 cycles; D, tx_ready and busy are all registered.
module clock_group_serial_tx #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIV    = 4
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              D,
    output logic              busy
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_W - 1);

    logic [1:0]        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [DATA_W-1:0] sh, sh_nxt;
    logic              d_nxt, ready_nxt, busy_nxt;
    logic              bit_end;

    // State and output registers
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            sh       <= '0;
            D        <= 1'b1;
            tx_ready <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            idx      <= idx_nxt;
            sh       <= sh_nxt;
            D        <= d_nxt;
            tx_ready <= ready_nxt;
            busy     <= busy_nxt;
        end
    end

    // Last cycle of the current bit; with DIV=1 every cycle is a bit boundary
    assign bit_end = (cnt == '0);

    // Next-state and next-output logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        sh_nxt    = sh;
        d_nxt     = D;
        ready_nxt = tx_ready;
        busy_nxt  = busy;

        case (state)
            S_IDLE: begin
                if (tx_valid && tx_ready) begin
                    state_nxt = S_START;
                    sh_nxt    = tx_data;
                    cnt_nxt   = CNT_RELOAD;
                    idx_nxt   = '0;
                    d_nxt     = 1'b0;
                    ready_nxt = 1'b0;
                    busy_nxt  = 1'b1;
                end else begin
                    // Also the first edge after reset release: ready rises, no handshake yet
                    ready_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                    d_nxt     = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_nxt = S_DATA;
                    d_nxt     = sh[0];
                    sh_nxt    = sh >> 1;
                    idx_nxt   = '0;
                    cnt_nxt   = CNT_RELOAD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_nxt = CNT_RELOAD;
                    if (idx == IDX_LAST) begin
                        state_nxt = S_STOP;
                        d_nxt     = 1'b1;
                    end else begin
                        d_nxt   = sh[0];
                        sh_nxt  = sh >> 1;
                        idx_nxt = idx + IDX_W'(1);
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                    d_nxt     = 1'b1;
                    ready_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
                d_nxt     = 1'b1;
                ready_nxt = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_clock_group_serial_tx.sv
// Bench for clock_group_serial_tx: directed and randomized frames checked against a
// timing model that maps each cycle offset after the handshake to the expected line level.
module tb_clock_group_serial_tx;

    localparam int unsigned W  = 8;
    localparam int unsigned DV = 4;
    localparam int FR = (W + 2) * DV;

    logic       clk1 = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       D;
    logic       busy;

    logic [0:0] c_data;
    logic       c_valid;
    logic       c_ready;
    logic       c_d;
    logic       c_busy;

    int checks = 0;
    int errors = 0;

    clock_group_serial_tx #(.DATA_W(W), .DIV(DV)) dut (
        .clk1(clk1), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .D(D), .busy(busy)
    );

    clock_group_serial_tx #(.DATA_W(1), .DIV(1)) dut_corner (
        .clk1(clk1), .rst(rst), .tx_data(c_data), .tx_valid(c_valid),
        .tx_ready(c_ready), .D(c_d), .busy(c_busy)
    );

    always #5 clk1 = ~clk1;

    // Line level t cycles after the handshake edge: start bit, payload LSB first, stop bit
    function automatic logic model_d(input logic [31:0] data, input int w, input int div, input int t);
        int b;
        b = t / div;
        if (b == 0) return 1'b0;
        if (b <= w) return data[b-1];
        return 1'b1;
    endfunction

    task automatic tick;
        @(posedge clk1);
        #1;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (tx_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        logic [2:0] obs;
        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; c_valid = 1'b0; c_data = 1'b0;
        #1;
        obs = {D, busy, tx_ready};
        checks++;
        if (obs !== 3'b100) begin errors++; $display("FAIL reset_state got=%b exp=100", obs); end
        repeat (2) tick();
        #3;
        rst = 1'b0; tx_valid = 1'b1; tx_data = 8'h55;
        checks++;
        if (tx_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge got=%b exp=0", tx_ready); end
        tick();
        obs = {D, busy, tx_ready};
        checks++;
        if (obs !== 3'b101) begin errors++; $display("FAIL first_edge_after_release got=%b exp=101", obs); end
        tx_valid = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL no_handshake_on_release_edge busy=%b exp=0", busy); end
        // Start a frame, then assert reset in the middle of a clock cycle
        tx_data = 8'h00; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        obs = {D, busy, tx_ready};
        checks++;
        if (obs !== 3'b010) begin errors++; $display("FAIL frame_start got=%b exp=010", obs); end
        tick();
        #3 rst = 1'b1;
        #1;
        obs = {D, busy, tx_ready};
        checks++;
        if (obs !== 3'b100) begin errors++; $display("FAIL async_reset got=%b exp=100", obs); end
        tick();
        #2 rst = 1'b0;
        tick();
        obs = {D, busy, tx_ready};
        checks++;
        if (obs !== 3'b101) begin errors++; $display("FAIL ready_after_release got=%b exp=101", obs); end
    endtask

    task automatic test_single_frame;
        bit ok;
        logic [2:0] obs, exp;
        wait_ready(ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL single_wait_ready got=%b exp=1", ok); end
        tx_data = 8'hA5; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0; tx_data = 8'($urandom);
        for (int t = 0; t < FR; t++) begin
            obs = {D, busy, tx_ready};
            exp = {model_d(32'h000000A5, W, DV, t), 1'b1, 1'b0};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL single_a5 t=%0d got=%b exp=%b", t, obs, exp); end
            tick();
        end
        obs = {D, busy, tx_ready};
        checks++;
        if (obs !== 3'b101) begin errors++; $display("FAIL single_end got=%b exp=101", obs); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        logic [2:0] obs, exp;
        wait_ready(ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL b2b_wait_ready got=%b exp=1", ok); end
        tx_data = 8'h3C; tx_valid = 1'b1;
        tick();
        tx_data = 8'hC3;
        for (int t = 0; t < FR; t++) begin
            obs = {D, busy, tx_ready};
            exp = {model_d(32'h3C, W, DV, t), 1'b1, 1'b0};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL b2b_first t=%0d got=%b exp=%b", t, obs, exp); end
            tick();
        end
        obs = {D, busy, tx_ready};
        checks++;
        if (obs !== 3'b101) begin errors++; $display("FAIL b2b_gap got=%b exp=101", obs); end
        tick();
        tx_valid = 1'b0; tx_data = 8'($urandom);
        for (int t = 0; t < FR; t++) begin
            obs = {D, busy, tx_ready};
            exp = {model_d(32'hC3, W, DV, t), 1'b1, 1'b0};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL b2b_second t=%0d got=%b exp=%b", t, obs, exp); end
            tick();
        end
        obs = {D, busy, tx_ready};
        checks++;
        if (obs !== 3'b101) begin errors++; $display("FAIL b2b_end got=%b exp=101", obs); end
    endtask

    task automatic test_busy_immunity;
        bit ok;
        logic [2:0] obs, exp;
        wait_ready(ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL busy_wait_ready got=%b exp=1", ok); end
        tx_data = 8'h00; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int t = 0; t < FR; t++) begin
            obs = {D, busy, tx_ready};
            exp = {model_d(32'h00, W, DV, t), 1'b1, 1'b0};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL busy_immunity t=%0d got=%b exp=%b", t, obs, exp); end
            if (t == 10) begin tx_valid = 1'b1; tx_data = 8'hFF; end
            if (t == 11) tx_valid = 1'b0;
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            obs = {D, busy, tx_ready};
            checks++;
            if (obs !== 3'b101) begin errors++; $display("FAIL busy_no_extra i=%0d got=%b exp=101", i, obs); end
            tick();
        end
    endtask

    task automatic test_mid_frame_reset;
        bit ok;
        logic [2:0] obs, exp;
        logic [1:0] idle;
        wait_ready(ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL midrst_wait_ready got=%b exp=1", ok); end
        tx_data = 8'hA5; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int t = 0; t <= 17; t++) begin
            obs = {D, busy, tx_ready};
            exp = {model_d(32'hA5, W, DV, t), 1'b1, 1'b0};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL midrst_pre t=%0d got=%b exp=%b", t, obs, exp); end
            if (t < 17) tick();
        end
        rst = 1'b1;
        #1;
        obs = {D, busy, tx_ready};
        checks++;
        if (obs !== 3'b100) begin errors++; $display("FAIL midrst_async got=%b exp=100", obs); end
        tick();
        #3 rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            idle = {D, busy};
            checks++;
            if (idle !== 2'b10) begin errors++; $display("FAIL midrst_no_resume i=%0d got=%b exp=10", i, idle); end
        end
    endtask

    task automatic test_random_frames;
        bit ok;
        logic [7:0] cap;
        logic [2:0] obs, exp;
        for (int f = 0; f < 20; f++) begin
            repeat ($urandom_range(0, 3)) tick();
            wait_ready(ok);
            checks++;
            if (ok !== 1'b1) begin errors++; $display("FAIL rand_wait_ready f=%0d got=%b exp=1", f, ok); end
            cap = 8'($urandom);
            tx_data = cap; tx_valid = 1'b1;
            tick();
            for (int t = 0; t < FR; t++) begin
                obs = {D, busy, tx_ready};
                exp = {model_d(32'(cap), W, DV, t), 1'b1, 1'b0};
                checks++;
                if (obs !== exp) begin errors++; $display("FAIL rand f=%0d data=%h t=%0d got=%b exp=%b", f, cap, t, obs, exp); end
                tx_data = 8'($urandom);
                tx_valid = (t < FR - 2) ? 1'($urandom) : 1'b0;
                tick();
            end
            obs = {D, busy, tx_ready};
            checks++;
            if (obs !== 3'b101) begin errors++; $display("FAIL rand_end f=%0d got=%b exp=101", f, obs); end
        end
    endtask

    task automatic test_corner_params;
        logic [2:0] obs, exp;
        for (int v = 0; v < 2; v++) begin
            checks++;
            if (c_ready !== 1'b1) begin errors++; $display("FAIL corner_ready_idle v=%0d got=%b exp=1", v, c_ready); end
            c_data = 1'(v); c_valid = 1'b1;
            tick();
            c_valid = 1'b0;
            for (int t = 0; t < 3; t++) begin
                obs = {c_d, c_busy, c_ready};
                exp = {model_d(32'(v), 1, 1, t), 1'b1, 1'b0};
                checks++;
                if (obs !== exp) begin errors++; $display("FAIL corner v=%0d t=%0d got=%b exp=%b", v, t, obs, exp); end
                tick();
            end
            obs = {c_d, c_busy, c_ready};
            checks++;
            if (obs !== 3'b101) begin errors++; $display("FAIL corner_end v=%0d got=%b exp=101", v, obs); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_busy_immunity();
        test_mid_frame_reset();
        test_random_frames();
        test_corner_params();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_group_serial_tx.md
CLOCK_GROUP_SERIAL_TX -- requirements
Module: clock_group_serial_tx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning payload bits per frame (legal range 1..32).
REQ-002 The block SHALL have parameter DIV, default 4, meaning clk1 cycles per transmitted bit (legal range 1..256).
REQ-003 The block SHALL have port clk1  input  1  meaning sole clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst  input  1  meaning reset, asynchronous and active-high.
REQ-005 The block SHALL have port tx_data  input  DATA_W  meaning parallel payload, sampled only at handshake.
REQ-006 The block SHALL have port tx_valid  input  1  meaning the upstream source offers tx_data.
REQ-007 The block SHALL have port tx_ready  output  1  meaning the block accepts a word (registered).
REQ-008 The block SHALL have port D  output  1  meaning registered serial line that drives the downstream capture flop D input; idle high.
REQ-009 The block SHALL have port busy  output  1  meaning a frame is in progress (registered).

Function
REQ-010 The block SHALL implement the states IDLE, START, DATA and STOP, with D driven high, low, payload bit and high respectively.
REQ-011 A handshake SHALL occur at rising edge k when tx_valid=1 and tx_ready=1 are both sampled; no other condition SHALL start a frame.
REQ-012 At handshake edge k the block SHALL capture tx_data into a shift register, enter START, drive D to 0, drive tx_ready to 0 and drive busy to 1.
REQ-013 Each bit SHALL last exactly DIV cycles, timed by a divide counter that reloads on every bit boundary.
REQ-014 The start bit SHALL occupy edges k..k+DIV-1.
REQ-015 Payload bit i (LSB first, i=0..DATA_W-1) SHALL appear on D from edge k+(1+i)*DIV.
REQ-016 The stop bit (D=1) SHALL appear from edge k+(DATA_W+1)*DIV for DIV cycles.
REQ-017 At edge k+(DATA_W+2)*DIV the block SHALL return to IDLE with tx_ready=1, busy=0 and D=1.
REQ-018 The earliest next handshake SHALL be at edge k+(DATA_W+2)*DIV+1, giving a minimum frame period of (DATA_W+2)*DIV+1 cycles.
REQ-019 While busy=1, tx_valid and tx_data SHALL be ignored, and changes to tx_data after the handshake SHALL NOT affect the frame in flight.
REQ-020 With DIV=1 the block SHALL shift one bit per cycle with no special casing, and the counter SHALL NOT underflow or wrap past DIV-1.
REQ-021 The bit counter SHALL count exactly DATA_W payload bits; DATA_W=1 SHALL produce a 3-bit frame.
REQ-022 tx_ready and busy SHALL never both be 1, and D SHALL change only on bit boundaries.

Reset
REQ-023 When rst=1, the block SHALL immediately, without waiting for a clock edge, force state=IDLE, D=1, tx_ready=0, busy=0 and clear the shift register and counters.
REQ-024 At the first clk1 rising edge after rst deasserts, the block SHALL set tx_ready=1, and a handshake SHALL NOT be possible on that edge.
REQ-025 Reset asserted mid-frame SHALL abort the frame, return D to 1 asynchronously, and SHALL NOT resume transmission after release.

Verification
REQ-026 Reset check: assert rst mid-cycle -> D=1, tx_ready=0, busy=0 before the next edge; after release, one edge later -> tx_ready=1.
REQ-027 Single frame (DATA_W=8, DIV=4, tx_data=8'hA5): D SHALL read 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles; tx_ready=1 at edge k+40.
REQ-028 Back-to-back: hold tx_valid=1 with 8'h3C then 8'hC3 -> second handshake exactly at edge k+41, and both frames SHALL be bit-exact.
REQ-029 Busy immunity: pulse tx_valid and change tx_data to 8'hFF at edge k+10 of an 8'h00 frame -> the payload SHALL stay all zeros and no extra frame SHALL be sent.
REQ-030 Mid-frame reset: assert rst at edge k+17 of an 8'hA5 frame -> D=1 immediately; after release, D SHALL remain 1 until a new handshake.
REQ-031 Corner parameters (DATA_W=1, DIV=1, tx_data=1'b0) -> D SHALL read 0,0,1 on consecutive cycles, with tx_ready=1 at edge k+3.
